signed_8b_square_accum: RTL and testbench

Windowed power accumulator placed directly downstream of `signed_8b_square`. It takes the 15-bit unsigned squared-sample stream, sums exactly 2^NSAMP_LOG2 valid samples per window, and presents one registered sum per window with a single-cycle valid strobe. It is the detector-power stage between the squarer and threshold/trigger logic.

---
 rtl/signed_8b_square_accum.sv | 87 ++++++++
 tb/tb_signed_8b_square_accum.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/signed_8b_square_accum.sv
// Windowed power accumulator: sums 2^NSAMP_LOG2 valid squared samples per window.
// Optional macro SQUARE_ACCUM_SATURATE_EN clamps the sum to all-ones on overflow instead of wrapping.
module signed_8b_square_accum #(
    parameter int NSAMP_LOG2 = 10,
    parameter int OUT_BITS   = 25
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [14:0]         sq_i,
    input  logic                sq_valid_i,
    input  logic                clear_i,
    output logic [OUT_BITS-1:0] sum_o,
    output logic                sum_valid_o,
    output logic                overflow_o
);

    logic [14:0]           r_sq_q;
    logic                  r_vld_q;
    logic [OUT_BITS-1:0]   r_acc;
    logic [NSAMP_LOG2-1:0] r_cnt;
    logic                  r_ovf;
    logic [OUT_BITS-1:0]   r_sum;
    logic                  r_sum_valid;
    logic                  r_overflow;

    logic [OUT_BITS:0]     w_sq_ext;
    logic [OUT_BITS:0]     w_sum_next;
    logic                  w_win_ovf;
    logic [OUT_BITS-1:0]   w_sum_lim;
    logic                  w_last;

    assign w_sq_ext   = {{(OUT_BITS + 1 - 15){1'b0}}, r_sq_q};
    assign w_sum_next = {1'b0, r_acc} + w_sq_ext;
    assign w_win_ovf  = w_sum_next[OUT_BITS] | r_ovf;
    assign w_last     = (r_cnt == {NSAMP_LOG2{1'b1}});

`ifdef SQUARE_ACCUM_SATURATE_EN
    // Once a window has overflowed it stays pinned at full scale until it completes.
    assign w_sum_lim = w_win_ovf ? {OUT_BITS{1'b1}} : w_sum_next[OUT_BITS-1:0];
`else
    assign w_sum_lim = w_sum_next[OUT_BITS-1:0];
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sq_q      <= '0;
            r_vld_q     <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_sum       <= '0;
            r_sum_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_sum_valid <= 1'b0;
            r_sq_q      <= sq_i;
            if (clear_i) begin
                // Clear beats a coinciding window completion: no strobe, outputs held.
                r_vld_q <= 1'b0;
                r_acc   <= '0;
                r_cnt   <= '0;
                r_ovf   <= 1'b0;
            end else begin
                r_vld_q <= sq_valid_i;
                if (r_vld_q) begin
                    if (w_last) begin
                        r_sum       <= w_sum_lim;
                        r_overflow  <= w_win_ovf;
                        r_sum_valid <= 1'b1;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_ovf       <= 1'b0;
                    end else begin
                        r_acc <= w_sum_lim;
                        r_cnt <= r_cnt + NSAMP_LOG2'(1);
                        r_ovf <= w_win_ovf;
                    end
                end
            end
        end
    end

    assign sum_o       = r_sum;
    assign sum_valid_o = r_sum_valid;
    assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_signed_8b_square_accum.sv
// Directed bench for signed_8b_square_accum: per-cycle vector table on two short-window
// instances (17-bit and 16-bit sums) plus an end-to-end 256-sample ramp window.
module tb_signed_8b_square_accum;

    localparam logic [14:0] G  = 15'h3039;
    localparam logic [14:0] MX = 15'd16384;
`ifdef SQUARE_ACCUM_SATURATE_EN
    localparam int SATV = 65535;
`else
    localparam int SATV = 0;
`endif

    typedef struct {
        logic        rst;
        logic        clr;
        logic        vld;
        logic [14:0] sq;
        logic        ev;
        int          sa;
        int          sb;
        logic        ob;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [14:0] sq;
    logic        vld;
    logic        clr;
    logic [14:0] sq_c;
    logic        vld_c;
    logic        clr_c;

    logic [16:0] sum_a;
    logic        sv_a;
    logic        ov_a;
    logic [15:0] sum_b;
    logic        sv_b;
    logic        ov_b;
    logic [22:0] sum_c;
    logic        sv_c;
    logic        ov_c;

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl[$];

    signed_8b_square_accum #(.NSAMP_LOG2(2), .OUT_BITS(17)) u_a (
        .clk_i(clk), .rst_i(rst), .sq_i(sq), .sq_valid_i(vld), .clear_i(clr),
        .sum_o(sum_a), .sum_valid_o(sv_a), .overflow_o(ov_a));

    signed_8b_square_accum #(.NSAMP_LOG2(2), .OUT_BITS(16)) u_b (
        .clk_i(clk), .rst_i(rst), .sq_i(sq), .sq_valid_i(vld), .clear_i(clr),
        .sum_o(sum_b), .sum_valid_o(sv_b), .overflow_o(ov_b));

    signed_8b_square_accum #(.NSAMP_LOG2(8), .OUT_BITS(23)) u_c (
        .clk_i(clk), .rst_i(rst), .sq_i(sq_c), .sq_valid_i(vld_c), .clear_i(clr_c),
        .sum_o(sum_c), .sum_valid_o(sv_c), .overflow_o(ov_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic c, input logic v, input logic [14:0] s,
                       input logic ev, input int sa, input int sb, input logic ob);
        vec_t e;
        e.rst = r; e.clr = c; e.vld = v; e.sq = s;
        e.ev = ev; e.sa = sa; e.sb = sb; e.ob = ob;
        tbl.push_back(e);
    endtask

    task automatic idle(input logic ev, input int sa, input int sb, input logic ob);
        add(1'b0, 1'b0, 1'b0, G, ev, sa, sb, ob);
    endtask

    task automatic smp(input logic [14:0] s, input int sa, input int sb, input logic ob);
        add(1'b0, 1'b0, 1'b1, s, 1'b0, sa, sb, ob);
    endtask

    initial begin
        longint model;
        int     strobes;
        longint got_sum;
        logic   got_ovf;

        rst = 1'b1; clr = 1'b0; sq = '0; vld = 1'b0;
        clr_c = 1'b0; sq_c = '0; vld_c = 1'b0;

        // reset, with traffic present that must be ignored
        add(1'b1, 1'b0, 1'b1, 15'd9, 1'b0, 0, 0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 15'd9, 1'b0, 0, 0, 1'b0);
        idle(1'b0, 0, 0, 1'b0);
        // continuous 1,2,3,4
        smp(15'd1, 0, 0, 1'b0); smp(15'd2, 0, 0, 1'b0);
        smp(15'd3, 0, 0, 1'b0); smp(15'd4, 0, 0, 1'b0);
        idle(1'b1, 10, 10, 1'b0);
        idle(1'b0, 10, 10, 1'b0);
        // gapped 100..400
        smp(15'd100, 10, 10, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b0, 10, 10, 1'b0);
        smp(15'd200, 10, 10, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b0, 10, 10, 1'b0);
        smp(15'd300, 10, 10, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b0, 10, 10, 1'b0);
        smp(15'd400, 10, 10, 1'b0);
        idle(1'b1, 1000, 1000, 1'b0);
        idle(1'b0, 1000, 1000, 1'b0);
        // back-to-back full-scale windows; the 16-bit instance overflows
        for (int i = 0; i < 4; i++) smp(MX, 1000, 1000, 1'b0);
        add(1'b0, 1'b0, 1'b1, MX, 1'b1, 65536, SATV, 1'b1);
        for (int i = 0; i < 3; i++) smp(MX, 65536, SATV, 1'b1);
        idle(1'b1, 65536, SATV, 1'b1);
        idle(1'b0, 65536, SATV, 1'b1);
        // clear mid-window
        smp(15'd5, 65536, SATV, 1'b1); smp(15'd5, 65536, SATV, 1'b1);
        add(1'b0, 1'b1, 1'b1, 15'd5, 1'b0, 65536, SATV, 1'b1);
        for (int i = 0; i < 4; i++) smp(15'd1, 65536, SATV, 1'b1);
        idle(1'b1, 4, 4, 1'b0);
        idle(1'b0, 4, 4, 1'b0);
        // clear coincident with completion, then a clean window
        for (int i = 0; i < 4; i++) smp(15'd7, 4, 4, 1'b0);
        add(1'b0, 1'b1, 1'b0, G, 1'b0, 4, 4, 1'b0);
        idle(1'b0, 4, 4, 1'b0);
        for (int i = 0; i < 4; i++) smp(15'd2, 4, 4, 1'b0);
        idle(1'b1, 8, 8, 1'b0);
        idle(1'b0, 8, 8, 1'b0);
        // reset clears held outputs
        add(1'b1, 1'b0, 1'b1, 15'd3, 1'b0, 0, 0, 1'b0);
        idle(1'b0, 0, 0, 1'b0);

        foreach (tbl[k]) begin
            @(negedge clk);
            rst = tbl[k].rst; clr = tbl[k].clr; vld = tbl[k].vld; sq = tbl[k].sq;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d valid_a", k), sv_a, tbl[k].ev);
            chk($sformatf("v%0d sum_a", k), sum_a, tbl[k].sa);
            chk($sformatf("v%0d ovf_a", k), ov_a, 0);
            chk($sformatf("v%0d valid_b", k), sv_b, tbl[k].ev);
            chk($sformatf("v%0d sum_b", k), sum_b, tbl[k].sb);
            chk($sformatf("v%0d ovf_b", k), ov_b, tbl[k].ob);
        end

        // end-to-end: squares of a -128..127 ramp into a 256-sample window
        model = 0;
        strobes = 0;
        got_sum = -1;
        got_ovf = 1'b1;
        for (int i = -128; i < 128; i++) begin
            @(negedge clk);
            sq_c = 15'(i * i);
            vld_c = 1'b1;
            model += i * i;
            @(posedge clk);
            #1;
            if (sv_c) strobes++;
        end
        @(negedge clk);
        vld_c = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(posedge clk);
            #1;
            if (sv_c) begin
                strobes++;
                got_sum = sum_c;
                got_ovf = ov_c;
            end
        end
        chk("e2e strobes", strobes, 1);
        chk("e2e sum", got_sum, model);
        chk("e2e ovf", got_ovf, 0);
        chk("e2e sum held", sum_c, model);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
